// File: rtl/ff_bank_rs.sv
// ff_bank_rs: bank of CHANNELS D flip-flops with synchronous preset/clear, per-channel enable and
// a global load/hold/toggle/shift mode. Define FF_BANK_CONFLICT_FLAG_EN to add the sticky conflict output.
module ff_bank_rs #(
  parameter int unsigned                CHANNELS  = 2,
  parameter logic [CHANNELS-1:0]        RESET_VAL = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] ce,
  input  logic [CHANNELS-1:0] d,
  input  logic [CHANNELS-1:0] set_n,
  input  logic [CHANNELS-1:0] clr_n,
  input  logic                sin,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] q_n,
`ifdef FF_BANK_CONFLICT_FLAG_EN
  output logic                conflict,
`endif
  output logic                sout
);

  localparam logic [1:0] MODE_LOAD   = 2'b00;
  localparam logic [1:0] MODE_HOLD   = 2'b01;
  localparam logic [1:0] MODE_TOGGLE = 2'b10;
  localparam logic [1:0] MODE_SHIFT  = 2'b11;

  // True when any channel has preset and clear asserted together.
  function automatic logic any_dual_assert(input logic [CHANNELS-1:0] s_n,
                                           input logic [CHANNELS-1:0] c_n);
    any_dual_assert = |(~s_n & ~c_n);
  endfunction

  // Mode-selected next value of one channel, used only when the channel is enabled.
  function automatic logic mode_bit(input logic [1:0] m,
                                    input logic       cur,
                                    input logic       din,
                                    input logic       shin);
    case (m)
      MODE_LOAD:   mode_bit = din;
      MODE_HOLD:   mode_bit = cur;
      MODE_TOGGLE: mode_bit = ~cur;
      MODE_SHIFT:  mode_bit = shin;
      default:     mode_bit = cur;
    endcase
  endfunction

  logic [CHANNELS-1:0] q_r;
  logic [CHANNELS-1:0] q_n_r;
  logic [CHANNELS-1:0] shift_src_s;
  logic [CHANNELS-1:0] q_next_s;
  logic [CHANNELS-1:0] q_n_next_s;

  // Serial chain source: channel i takes the pre-edge q of channel i-1, channel 0 takes sin.
  always_comb begin
    shift_src_s    = q_r;
    shift_src_s[0] = sin;
    for (int i = 1; i < int'(CHANNELS); i++) begin
      shift_src_s[i] = q_r[i-1];
    end
  end

  // Per-channel priority: dual assert, preset, clear, enable-off hold, then mode.
  always_comb begin
    q_next_s   = q_r;
    q_n_next_s = ~q_r;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (!set_n[i] && !clr_n[i]) begin
        // Both outputs high, as the original 74S74 does with both inputs asserted.
        q_next_s[i]   = 1'b1;
        q_n_next_s[i] = 1'b1;
      end else if (!set_n[i]) begin
        q_next_s[i]   = 1'b1;
        q_n_next_s[i] = 1'b0;
      end else if (!clr_n[i]) begin
        q_next_s[i]   = 1'b0;
        q_n_next_s[i] = 1'b1;
      end else if (!ce[i]) begin
        q_next_s[i]   = q_r[i];
        q_n_next_s[i] = ~q_r[i];
      end else begin
        q_next_s[i]   = mode_bit(mode, q_r[i], d[i], shift_src_s[i]);
        q_n_next_s[i] = ~mode_bit(mode, q_r[i], d[i], shift_src_s[i]);
      end
    end
  end

  // State registers; q_n is separate so the dual-assert state is representable.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r   <= RESET_VAL;
      q_n_r <= ~RESET_VAL;
    end else begin
      q_r   <= q_next_s;
      q_n_r <= q_n_next_s;
    end
  end

`ifdef FF_BANK_CONFLICT_FLAG_EN
  logic conflict_r;

  // Sticky conflict flag; only reset clears it, and a reset edge never sets it.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_r <= 1'b0;
    end else if (any_dual_assert(set_n, clr_n)) begin
      conflict_r <= 1'b1;
    end else begin
      conflict_r <= conflict_r;
    end
  end

  assign conflict = conflict_r;
`endif

  assign q    = q_r;
  assign q_n  = q_n_r;
  assign sout = q_r[CHANNELS-1];

endmodule

// File: tb/tb_ff_bank_rs.sv
// Directed self-checking bench for ff_bank_rs with CHANNELS=4, RESET_VAL=4'b1010.
module tb_ff_bank_rs;

  localparam int unsigned CH = 4;

  logic          clk;
  logic          reset;
  logic [1:0]    mode;
  logic [CH-1:0] ce;
  logic [CH-1:0] d;
  logic [CH-1:0] set_n;
  logic [CH-1:0] clr_n;
  logic          sin;
  logic [CH-1:0] q;
  logic [CH-1:0] q_n;
  logic          sout;
`ifdef FF_BANK_CONFLICT_FLAG_EN
  logic          conflict;
`endif

  int total_cnt;
  int bad_cnt;

  ff_bank_rs #(
    .CHANNELS (CH),
    .RESET_VAL(4'b1010)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .ce      (ce),
    .d       (d),
    .set_n   (set_n),
    .clr_n   (clr_n),
    .sin     (sin),
    .q       (q),
    .q_n     (q_n),
`ifdef FF_BANK_CONFLICT_FLAG_EN
    .conflict(conflict),
`endif
    .sout    (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_q(input string tag, input logic [CH-1:0] eq, input logic [CH-1:0] eqn);
    check_val({tag, ".q"}, 32'(q), 32'(eq));
    check_val({tag, ".q_n"}, 32'(q_n), 32'(eqn));
    check_val({tag, ".sout"}, 32'(sout), 32'(eq[CH-1]));
  endtask

  logic [CH-1:0] tog_exp [3];
  logic [CH-1:0] sh_exp  [4];
  logic          sh_sin  [4];

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    tog_exp   = '{4'b0011, 4'b0000, 4'b0011};
    sh_exp    = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
    sh_sin    = '{1'b1, 1'b0, 1'b1, 1'b1};

    reset = 1'b1; mode = 2'b01; ce = 4'b1111; d = 4'b0000;
    set_n = 4'b1111; clr_n = 4'b1111; sin = 1'b0;
    step();
    check_q("reset", 4'b1010, 4'b0101);
`ifdef FF_BANK_CONFLICT_FLAG_EN
    check_val("conflict.reset", 32'(conflict), 32'd0);
`endif

    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_q("hold", 4'b1010, 4'b0101);
    end

    mode = 2'b00; d = 4'b0110; ce = 4'b1111;
    step();
    check_q("load", 4'b0110, 4'b1001);
    ce = 4'b0000; d = 4'b1111;
    step();
    check_q("load_ce_off", 4'b0110, 4'b1001);

    ce = 4'b1111; d = 4'b0000;
    step();
    check_q("load_zero", 4'b0000, 4'b1111);

    mode = 2'b10; ce = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step();
      check_q("toggle", tog_exp[i], ~tog_exp[i]);
    end

    mode = 2'b01; ce = 4'b1111; clr_n = 4'b0000;
    step();
    check_q("clear", 4'b0000, 4'b1111);
    clr_n = 4'b1111;

    mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      sin = sh_sin[i];
      step();
      check_q("shift", sh_exp[i], ~sh_exp[i]);
    end

    // Channel 1 held: it keeps its value yet still feeds its pre-edge q to channel 2.
    ce = 4'b1101; sin = 1'b0;
    step();
    check_q("shift_held", 4'b0110, 4'b1001);

    // Channel 0 preset during shift: channel 1 still gets channel 0's pre-edge value.
    ce = 4'b1111; set_n = 4'b1110;
    step();
    check_q("shift_preset", 4'b1101, 4'b0010);
    set_n = 4'b1111;

    mode = 2'b01; clr_n = 4'b0000;
    step();
    check_q("clear2", 4'b0000, 4'b1111);
    clr_n = 4'b1111;

    set_n = 4'b1011; clr_n = 4'b1011;
    step();
    check_q("dual", 4'b0100, 4'b1111);
`ifdef FF_BANK_CONFLICT_FLAG_EN
    check_val("conflict.set", 32'(conflict), 32'd1);
`endif
    set_n = 4'b1111; clr_n = 4'b1111; ce = 4'b0000;
    step();
    check_q("dual_release", 4'b0100, 4'b1011);
`ifdef FF_BANK_CONFLICT_FLAG_EN
    check_val("conflict.sticky", 32'(conflict), 32'd1);
`endif

    mode = 2'b11; ce = 4'b1111; sin = 1'b1;
    step();
    check_q("midshift1", 4'b1001, 4'b0110);
    step();
    check_q("midshift2", 4'b0011, 4'b1100);

    // Reset wins over a simultaneous preset and a dual assert on channel 0.
    reset = 1'b1; set_n = 4'b1110; clr_n = 4'b1110;
    step();
    check_q("midshift_reset", 4'b1010, 4'b0101);
`ifdef FF_BANK_CONFLICT_FLAG_EN
    check_val("conflict.reset_dual", 32'(conflict), 32'd0);
`endif
    reset = 1'b0; set_n = 4'b1111; clr_n = 4'b1111; sin = 1'b0;
    step();
    check_q("post_reset_shift", 4'b0100, 4'b1011);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
